function_arith_inverse: RTL and testbench
=========================================

# function_arith_inverse

Sequential inverse solver for the team's arithmetic function f(x,y,z) = ((((x+y)−z) << 1) | (x & y)) ^ z, with all terms truncated to WIDTH bits. Given a target value and fixed operands b and c, the block searches candidate values of a in ascending order and returns the smallest a with f(a,b,c) == target, or reports that none exists. It sits downstream of the function_arith datapath as its inverse and checker, for recovering the first operand from a known result.

## Interface
- WIDTH, default 8: operand and result width.
- clk  input  1: single clock; all state changes on the rising edge.
- rst  input  1: synchronous, active-high reset.
- start  input  1: request a search; accepted only in IDLE.
- target  input  WIDTH: value to invert; sampled on the accepting edge.
- b  input  WIDTH: second operand; sampled on the accepting edge.
- c  input  WIDTH: third operand; sampled on the accepting edge.
- busy  output  1: high in SEARCH.
- done  output  1: one-cycle pulse when a result is valid.
- found  output  1: a match exists; held until the next accepted start.
- a_out  output  WIDTH: smallest matching a; 0 when found=0; held.
- tries  output  WIDTH+1: candidates examined; held.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE with start=1: latch target, b and c; clear found, a_out and tries; set candidate=0; go to SEARCH.
- SEARCH, each cycle: evaluate f(candidate, b_q, c_q) combinationally.
  - Match: a_out=candidate, found=1, tries=candidate+1; go to DONE.
  - No match and candidate == 2^WIDTH−1: found=0, a_out=0, tries=2^WIDTH; go to DONE.
  - Otherwise increment candidate.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SEARCH and DONE. It is not queued.
- Live target, b and c inputs are don't-care after the accepting edge.
- Arithmetic: the sum, difference and shift wrap modulo 2^WIDTH. The shift discards the MSB.
- The candidate counter must not wrap. The exhaustion check fires at the all-ones candidate.
- The tries counter is WIDTH+1 bits so that 2^WIDTH is representable.

## Timing
- Reset values: busy=0, done=0, found=0, a_out=0, tries=0, state=IDLE.
- Reset mid-search aborts immediately. No done pulse is produced for the aborted search.
- Count edges from the start-accepting edge as edge 0.
  - Match at candidate k: done is high in the cycle after edge k+2.
  - No match: done is high in the cycle after edge 2^WIDTH+1.
- busy is high from edge 1 through the edge that enters DONE. busy is low while done is high.
- A start held high through DONE is accepted on the first IDLE edge. The back-to-back gap is one IDLE cycle.

## Configuration
- DUAL_LANE, macro ARITH_INV_DUAL_LANE_EN.
  - Defined: two evaluators check candidates 2j and 2j+1 each cycle, and the candidate steps by 2.
  - If both lanes match, the even lane wins, so a_out is still the smallest match.
  - Match at k: done is high after edge ⌊k/2⌋+2. No match: done after edge 2^(WIDTH−1)+1.
  - tries and a_out semantics are unchanged.
- Undefined: single lane, as described above.

## Structure
- Package function_arith_pkg holds:
  - the state enum typedef (IDLE/SEARCH/DONE);
  - a localparam for the default WIDTH;
  - a parameterized automatic function for f, shared with the function_arith datapath.
- One sub-module, arith_eval: purely combinational f(x,y,z) evaluator with WIDTH as a parameter.
  - Instantiated once in single-lane mode and twice under ARITH_INV_DUAL_LANE_EN.

## Test plan
- WIDTH=8, target=14, b=3, c=1 → found=1, a_out=5, tries=6; done after edge 7 (edge 4 in dual lane).
- target=0, b=0, c=0 → found=1, a_out=0, tries=1; done after edge 2 in both modes.
- target=1, b=0, c=0 → found=0, a_out=0, tries=256; done after edge 257 (edge 129 in dual lane). Bit 0 of f is (a0&b0)^c0, so no a can produce an odd target here.
- start re-pulsed at edge 3 during the first vector above → ignored; result identical; exactly one done pulse.
- rst asserted at edge 3 during the first vector above → next cycle busy=0, found=0, tries=0, no done; a new start then completes normally.
- Back-to-back: start held high → second search accepted one cycle after done. The second search's a_out matches its own b and c.

Source files
------------

// File: rtl/function_arith_pkg.sv
// Shared types and the f(x,y,z) reference used by function_arith and its inverse solver.
package function_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int F_MAX_WIDTH   = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Evaluated at full width; callers truncate. Every term only depends on
    // equal-or-lower bits, so truncating the result equals computing narrow.
    function automatic logic [F_MAX_WIDTH-1:0] arith_f(
        input logic [F_MAX_WIDTH-1:0] x,
        input logic [F_MAX_WIDTH-1:0] y,
        input logic [F_MAX_WIDTH-1:0] z
    );
        return ((((x + y) - z) << 1) | (x & y)) ^ z;
    endfunction

endpackage

// File: rtl/arith_eval.sv
// Combinational evaluator for f(x,y,z) = ((((x+y)-z) << 1) | (x & y)) ^ z, WIDTH bits (WIDTH < 64).
module arith_eval
    import function_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] f
);

    assign f = WIDTH'(arith_f(F_MAX_WIDTH'(x), F_MAX_WIDTH'(y), F_MAX_WIDTH'(z)));

endmodule

// File: rtl/function_arith_inverse.sv
// Ascending search for the smallest a with f(a,b,c) == target.
// Define ARITH_INV_DUAL_LANE_EN to test two candidates (2j, 2j+1) per cycle.
module function_arith_inverse
    import function_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH:0]   tries,
    output state_t           state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, b_q, c_q;
    logic [WIDTH-1:0] cand;
    logic             busy_q, done_q, found_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   tries_q;

    logic [WIDTH-1:0] f_even;
    logic             match_even, match_odd, hit, last;
    logic [WIDTH-1:0] hit_a;
    logic [WIDTH:0]   hit_tries;

    arith_eval #(.WIDTH(WIDTH)) u_eval_even (
        .x (cand),
        .y (b_q),
        .z (c_q),
        .f (f_even)
    );
    assign match_even = (f_even == target_q);

`ifdef ARITH_INV_DUAL_LANE_EN
    logic [WIDTH-1:0] cand_odd, f_odd;
    localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

    assign cand_odd = {cand[WIDTH-1:1], 1'b1};
    arith_eval #(.WIDTH(WIDTH)) u_eval_odd (
        .x (cand_odd),
        .y (b_q),
        .z (c_q),
        .f (f_odd)
    );
    assign match_odd = (f_odd == target_q);
    assign last      = &cand_odd;
    // Even lane wins a double hit so a_out stays the smallest match.
    assign hit_a     = match_even ? cand : cand_odd;
`else
    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    assign match_odd = 1'b0;
    assign last      = &cand;
    assign hit_a     = cand;
`endif

    assign hit       = match_even | match_odd;
    assign hit_tries = {1'b0, hit_a} + (WIDTH+1)'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SEARCH;
            SEARCH:  if (hit || last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are registered from the state, so they trail it by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cand     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            a_q      <= '0;
            tries_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_q == SEARCH);
            done_q  <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_q <= target;
                        b_q      <= b;
                        c_q      <= c;
                        cand     <= '0;
                        found_q  <= 1'b0;
                        a_q      <= '0;
                        tries_q  <= '0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        found_q <= 1'b1;
                        a_q     <= hit_a;
                        tries_q <= hit_tries;
                    end else if (last) begin
                        found_q <= 1'b0;
                        a_q     <= '0;
                        tries_q <= {1'b1, {WIDTH{1'b0}}};
                    end else begin
                        cand <= cand + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign a_out = a_q;
    assign tries = tries_q;
    assign state = state_q;

endmodule

// File: tb/tb_function_arith_inverse.sv
// Bench for function_arith_inverse: vector table, scoreboard queue, and multi-cycle corner sequences.
module tb_function_arith_inverse;
    import function_arith_pkg::*;

    localparam int W  = 8;
    localparam int EW = 2*W + 2;
`ifdef ARITH_INV_DUAL_LANE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   target = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic           busy, done, found;
    logic [W-1:0]   a_out;
    logic [W:0]     tries;
    state_t         state;

    function_arith_inverse #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .b      (b),
        .c      (c),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .a_out  (a_out),
        .tries  (tries),
        .state  (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         ef;
        logic [W-1:0] ea;
        logic [W:0]   et;
        int           lat;
    } vec_t;

    vec_t           vecs[8];
    logic [EW-1:0]  exp_q[$];
    int             lat_q[$];
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] model_f(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
        logic [W-1:0] s, d, sh;
        s  = x + y;
        d  = s - z;
        sh = {d[W-2:0], 1'b0};
        return (sh | (x & y)) ^ z;
    endfunction

    function automatic int lat_of(input logic f, input logic [W-1:0] a);
        if (!f) return DUAL ? (1 << (W-1)) + 1 : (1 << W) + 1;
        return DUAL ? int'(a) / 2 + 2 : int'(a) + 2;
    endfunction

    function automatic void model_fill(inout vec_t v);
        v.ef = 1'b0;
        v.ea = '0;
        v.et = (W+1)'(1 << W);
        for (int i = 0; i < (1 << W); i++) begin
            if (model_f(W'(i), v.b, v.c) == v.t) begin
                v.ef = 1'b1;
                v.ea = W'(i);
                v.et = (W+1)'(i + 1);
                break;
            end
        end
        v.lat = lat_of(v.ef, v.ea);
    endfunction

    // Driver: called #1 after an edge with the DUT in IDLE; returns #1 after the accepting edge.
    task automatic launch(input vec_t v, input bit hold_start);
        start  = 1'b1;
        target = v.t;
        b      = v.b;
        c      = v.c;
        exp_q.push_back({v.ef, v.ea, v.et});
        lat_q.push_back(v.lat);
        @(posedge clk);
        #1;
        if (!hold_start) begin
            start  = 1'b0;
            target = W'($urandom_range(0, 255));
            b      = W'($urandom_range(0, 255));
            c      = W'($urandom_range(0, 255));
        end
    endtask

    // Monitor: counts edges after the accepting edge until done, then scores the result.
    task automatic wait_done(input string name, input int repulse_at, input bit tail);
        int n;
        logic [EW-1:0] e;
        n = 0;
        for (int k = 0; k < 700; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (repulse_at > 0 && n == repulse_at - 1) start = 1'b1;
            if (repulse_at > 0 && n == repulse_at) start = 1'b0;
            if (n == 1 && !done) check({name, "_busy_e1"}, busy, 1);
            if (done) break;
        end
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, "_sb_underflow"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_found"}, found, e[EW-1]);
        check({name, "_a_out"}, a_out, e[2*W:W+1]);
        check({name, "_tries"}, tries, e[W:0]);
        check({name, "_latency"}, n, lat_q.pop_front());
        check({name, "_busy_low_at_done"}, busy, 0);
        if (tail) begin
            @(posedge clk);
            #1;
            check({name, "_done_one_cycle"}, done, 0);
            check({name, "_found_held"}, found, e[EW-1]);
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    initial begin
        int extra;
        logic [W-1:0] pick;

        vecs[0] = '{t: 8'd14, b: 8'd3, c: 8'd1, ef: 1'b1, ea: 8'd5, et: 9'd6,   lat: DUAL ? 4 : 7};
        vecs[1] = '{t: 8'd0,  b: 8'd0, c: 8'd0, ef: 1'b1, ea: 8'd0, et: 9'd1,   lat: 2};
        vecs[2] = '{t: 8'd1,  b: 8'd0, c: 8'd0, ef: 1'b0, ea: 8'd0, et: 9'd256, lat: DUAL ? 129 : 257};
        for (int i = 3; i < 8; i++) begin
            vecs[i].b = W'($urandom_range(0, 255));
            vecs[i].c = W'($urandom_range(0, 255));
            pick      = W'($urandom_range(0, 255));
            vecs[i].t = (i < 6) ? model_f(pick, vecs[i].b, vecs[i].c) : W'($urandom_range(0, 255));
            model_fill(vecs[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_a_out", a_out, 0);
        check("rst_tries", tries, 0);
        check("rst_state", state, IDLE);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i], 1'b0);
            wait_done($sformatf("vec%0d", i), 0, 1'b1);
        end

        launch(vecs[0], 1'b0);
        wait_done("repulse", 3, 1'b1);
        count_dones(300, extra);
        check("repulse_extra_done", extra, 0);

        start  = 1'b1;
        target = vecs[0].t;
        b      = vecs[0].b;
        c      = vecs[0].c;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_found", found, 0);
        check("abort_tries", tries, 0);
        check("abort_done", done, 0);
        check("abort_state", state, IDLE);
        count_dones(300, extra);
        check("abort_no_done", extra, 0);
        launch(vecs[0], 1'b0);
        wait_done("after_abort", 0, 1'b1);

        launch(vecs[0], 1'b1);
        wait_done("b2b_first", 0, 1'b0);
        target = vecs[1].t;
        b      = vecs[1].b;
        c      = vecs[1].c;
        exp_q.push_back({vecs[1].ef, vecs[1].ea, vecs[1].et});
        lat_q.push_back(vecs[1].lat);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_at_accept", busy, 0);
        wait_done("b2b_second", 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
